cfg_reg_arbiter: RTL
====================

// Module: cfg_reg_arbiter
// PURPOSE
//  Owns the 5-entry configuration register bank (output enables, PWM enables, PWM duty) and
//  shares write access between two requesters: port 0 = SPI command decoder, port 1 = on-chip
//  sequencer/loader. Arbitrates, commits one 8-bit write at a time, and acknowledges each
//  request with a one-cycle ready pulse. Downstream PWM/output logic reads the registers directly.
// PARAMETERS
//  FIXED_PRIO   0   0 = round-robin between ports; 1 = port 0 always wins a simultaneous request
//  HOLD_CYCLES  1   idle cycles after each ack before a new grant (1..3); lets requester drop valid
// PORTS
//  clk              in   1  system clock, single clock domain
//  rst_n            in   1  asynchronous active-low reset
//  req0_valid       in   1  port 0 write request
//  req0_addr        in   7  port 0 register address
//  req0_data        in   8  port 0 write data
//  req0_ready       out  1  port 0 ack pulse (1 cycle)
//  req1_valid       in   1  port 1 write request
//  req1_addr        in   7  port 1 register address
//  req1_data        in   8  port 1 write data
//  req1_ready       out  1  port 1 ack pulse (1 cycle)
//  lock_port1       in   1  when 1, port 1 writes are acked but not committed (flagged as error)
//  en_reg_out_7_0   out  8  addr 0x00
//  en_reg_out_15_8  out  8  addr 0x01
//  en_reg_pwm_7_0   out  8  addr 0x02
//  en_reg_pwm_15_8  out  8  addr 0x03
//  pwm_duty_cycle   out  8  addr 0x04
//  wr_done          out  1  pulse: a write was committed to the bank
//  wr_err           out  1  pulse: request acked but dropped (addr > 0x04, or port 1 while locked)
//  grant_id         out  1  port of the most recent grant (held until next grant)
//  wr_count         out  8  committed-write counter, saturates at 255
// BEHAVIOUR
//  - Reset (async, rst_n=0): all five registers, wr_count = 0x00; ready/wr_done/wr_err = 0;
//    grant_id = 0; round-robin pointer favours port 0; FSM -> IDLE. Reset mid-write aborts it:
//    no partial register update, no ack.
//  - FSM: IDLE -> WRITE -> HOLD -> IDLE.
//    IDLE: if any valid, select winner, latch its addr/data and grant_id, go WRITE; else stay.
//    WRITE (1 cycle): addr <= 0x04 and not (port 1 & lock_port1): update register, wr_done=1,
//      wr_count+1 (sat.); otherwise wr_err=1, bank unchanged. Winner's readyN=1 this cycle.
//      Flip round-robin pointer to the loser. Go HOLD.
//    HOLD: count HOLD_CYCLES cycles, ignore valids, then IDLE.
//  - Latency: valid seen in IDLE at edge N -> register value and readyN visible after edge N+1.
//    Min spacing between grants = 2 + HOLD_CYCLES cycles.
//  - Handshake: requester holds valid/addr/data stable until it samples its ready=1, then drops
//    valid the next cycle. Data sampled only in IDLE; changes during WRITE/HOLD have no effect.
//  - Arbitration: round-robin (FIXED_PRIO=0): on simultaneous valid, the port not granted last
//    wins; single valid always wins. FIXED_PRIO=1: port 0 wins ties; port 1 can starve (intended).
//  - Address compare uses the full 7 bits; 0x05..0x7F error, never alias.
//  - lock_port1 sampled in WRITE; port 0 never affected by lock.
//  - Outputs are registered; ready/wr_done/wr_err never high for more than one consecutive cycle;
//    req0_ready and req1_ready never high together.
// TESTING
//  1 Reset: drive writes, assert rst_n=0 mid-WRITE -> all regs 0x00, wr_count 0, no ready pulse.
//  2 Port 0 alone, addr 0x04 data 0xA5 -> pwm_duty_cycle=0xA5 one cycle after grant, req0_ready,
//    wr_done pulse, wr_count=1, grant_id=0.
//  3 Both valid every cycle, RR, addr 0x00 data 0x11 (p0) / 0x22 (p1) -> grants alternate
//    0,1,0,1; spacing exactly 3 cycles with HOLD_CYCLES=1; no double ready.
//  4 Port 1 addr 0x05 -> req1_ready + wr_err, bank unchanged, wr_count unchanged; repeat with
//    addr 0x02 and lock_port1=1 -> same; lock_port1=0 -> en_reg_pwm_7_0 updated.
//  5 FIXED_PRIO=1, both valid continuously -> port 0 granted every time, port 1 never.
//  6 300 valid writes -> wr_count saturates at 0xFF, no wrap.

Source files
------------

// File: rtl/cfg_reg_arbiter_if.sv
// rtl/cfg_reg_arbiter_if.sv - two-port register write request bus for cfg_reg_arbiter
interface cfg_reg_arbiter_if;
    logic       req0_valid;
    logic [6:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// rtl/cfg_reg_arbiter.sv - 5-entry config register bank shared by SPI decoder and sequencer
module cfg_reg_arbiter #(
    parameter bit          FIXED_PRIO  = 1'b0,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cfg_reg_arbiter_if.slave         bus,
    input  logic                     lock_port1,
    output logic [7:0]               en_reg_out_7_0,
    output logic [7:0]               en_reg_out_15_8,
    output logic [7:0]               en_reg_pwm_7_0,
    output logic [7:0]               en_reg_pwm_15_8,
    output logic [7:0]               pwm_duty_cycle,
    output logic                     wr_done,
    output logic                     wr_err,
    output logic                     grant_id,
    output logic [7:0]               wr_count
);

    localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] hold_cnt_q;
    logic       rr_q;
    logic       grant_q;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
    logic       ready0_q, ready1_q, wr_done_q, wr_err_q;
    logic [7:0] wr_count_q;

    logic       winner_d;
    logic       commit_ok;

    // rr_q names the port favoured on a tie; fixed priority ignores it.
    assign winner_d  = (bus.req0_valid && bus.req1_valid) ? (FIXED_PRIO ? 1'b0 : rr_q)
                                                          : bus.req1_valid;
    assign commit_ok = (addr_q <= 7'h04) && !(grant_q && lock_port1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= 2'd0;
            rr_q       <= 1'b0;
            grant_q    <= 1'b0;
            addr_q     <= 7'h00;
            data_q     <= 8'h00;
            out_lo_q   <= 8'h00;
            out_hi_q   <= 8'h00;
            pwm_lo_q   <= 8'h00;
            pwm_hi_q   <= 8'h00;
            duty_q     <= 8'h00;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_count_q <= 8'h00;
        end else begin
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        grant_q <= winner_d;
                        addr_q  <= winner_d ? bus.req1_addr : bus.req0_addr;
                        data_q  <= winner_d ? bus.req1_data : bus.req0_data;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (commit_ok) begin
                        case (addr_q[2:0])
                            3'd0:    out_lo_q <= data_q;
                            3'd1:    out_hi_q <= data_q;
                            3'd2:    pwm_lo_q <= data_q;
                            3'd3:    pwm_hi_q <= data_q;
                            3'd4:    duty_q   <= data_q;
                            default: ;
                        endcase
                        wr_done_q <= 1'b1;
                        if (wr_count_q != 8'hFF)
                            wr_count_q <= wr_count_q + 8'd1;
                    end else begin
                        wr_err_q <= 1'b1;
                    end
                    ready0_q   <= !grant_q;
                    ready1_q   <= grant_q;
                    rr_q       <= !grant_q;
                    hold_cnt_q <= 2'd0;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST)
                        state_q <= IDLE;
                    else
                        hold_cnt_q <= hold_cnt_q + 2'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready  = ready0_q;
    assign bus.req1_ready  = ready1_q;
    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_done         = wr_done_q;
    assign wr_err          = wr_err_q;
    assign grant_id        = grant_q;
    assign wr_count        = wr_count_q;

endmodule
